// File: rtl/ik_fixed_pkg.sv
// ik_fixed_pkg: 36-bit signed fixed-point types, constants and the round-and-shift helper
package ik_fixed_pkg;
  localparam int WIDTH = 36;
  localparam int FRAC_BITS = 16;
  typedef logic signed [WIDTH-1:0] fix_t;
  typedef logic signed [2*WIDTH-1:0] fix_wide_t;
  localparam fix_t FIX_ONE = 36'sh0_0001_0000;
  localparam fix_t FIX_MAX = 36'sh7_FFFF_FFFF;
  localparam fix_t FIX_MIN = 36'sh8_0000_0000;
  function automatic fix_wide_t fix_round_shift(input fix_wide_t x);
    return (x + (fix_wide_t'(1) <<< (FRAC_BITS-1))) >>> FRAC_BITS;
  endfunction
endpackage

// File: rtl/shared_mult_bank_lane.sv
// mult_lane: pipelined signed fixed-point multiplier; SHARED_MULT_SAT_EN selects clamp instead of wrap
module mult_lane
  import ik_fixed_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  fix_t a,
  input  fix_t b,
  output fix_t result,
  output logic ovf
);
  fix_t a_q, b_q, res_next;
  fix_wide_t prod, final_in;
  assign prod = fix_wide_t'(a_q) * fix_wide_t'(b_q);
  generate
    if (LATENCY > 2) begin : g_delay
      fix_wide_t dly [LATENCY-2];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < LATENCY-2; k++) dly[k] <= '0;
        end else if (en) begin
          dly[0] <= prod;
          for (int k = 1; k < LATENCY-2; k++) dly[k] <= dly[k-1];
        end
      end
      assign final_in = dly[LATENCY-3];
    end else begin : g_direct
      assign final_in = prod;
    end
  endgenerate
`ifdef SHARED_MULT_SAT_EN
  fix_wide_t sh;
  always_comb begin
    sh = fix_round_shift(final_in);
    ovf = sh[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){sh[WIDTH-1]}};
    res_next = ovf ? (sh[2*WIDTH-1] ? FIX_MIN : FIX_MAX) : fix_t'(sh);
  end
`else
  always_comb begin
    res_next = fix_t'(fix_round_shift(final_in));
    ovf = 1'b0;
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      result <= '0;
    end else if (en) begin
      a_q <= a;
      b_q <= b;
      result <= res_next;
    end
  end
endmodule

// File: rtl/shared_mult_bank.sv
// shared_mult_bank: 42-lane shared multiplier bank with count echo; SHARED_MULT_SAT_EN enables saturation/ovf_sticky
module shared_mult_bank
  import ik_fixed_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  req_valid,
  input  logic [7:0]            count,
  input  logic [5:0][35:0]      array_mult_dataa,
  input  logic [5:0][35:0]      array_mult_datab,
  input  logic [5:0][5:0][35:0] mat_mult_dataa,
  input  logic [5:0][5:0][35:0] mat_mult_datab,
  output logic [5:0][35:0]      array_mult_result,
  output logic [5:0][5:0][35:0] mat_mult_result,
  output logic                  result_valid,
  output logic [7:0]            result_count,
  output logic                  ovf_sticky
);
  logic [LATENCY-1:0] vld;
  logic [7:0] cnt [LATENCY];
  logic [41:0] lane_ovf;
  generate
    for (genvar i = 0; i < 6; i++) begin : g_arr
      mult_lane #(.LATENCY(LATENCY)) u_lane (
        .clk(clk), .rst(rst), .en(en),
        .a(array_mult_dataa[i]), .b(array_mult_datab[i]),
        .result(array_mult_result[i]), .ovf(lane_ovf[i])
      );
    end
    for (genvar r = 0; r < 6; r++) begin : g_row
      for (genvar c = 0; c < 6; c++) begin : g_col
        mult_lane #(.LATENCY(LATENCY)) u_lane (
          .clk(clk), .rst(rst), .en(en),
          .a(mat_mult_dataa[r][c]), .b(mat_mult_datab[r][c]),
          .result(mat_mult_result[r][c]), .ovf(lane_ovf[6+r*6+c])
        );
      end
    end
  endgenerate
  // vld[LATENCY-2] marks the request whose result the lanes register on this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < LATENCY; k++) cnt[k] <= '0;
      ovf_sticky <= 1'b0;
    end else if (en) begin
      vld <= {vld[LATENCY-2:0], req_valid};
      cnt[0] <= count;
      for (int k = 1; k < LATENCY; k++) cnt[k] <= cnt[k-1];
      ovf_sticky <= ovf_sticky | (vld[LATENCY-2] & |lane_ovf);
    end
  end
  assign result_valid = vld[LATENCY-1];
  assign result_count = cnt[LATENCY-1];
endmodule

// File: tb/tb_shared_mult_bank.sv
// tb_shared_mult_bank: directed and random checks of shared_mult_bank against a delay-line reference model
module tb_shared_mult_bank;
  import ik_fixed_pkg::*;
  localparam int LAT = 3;
  logic clk = 0, rst = 1, en = 0, req_valid = 0;
  logic [7:0] count = 0;
  logic [5:0][35:0] aa = '0, ab = '0, am_res;
  logic [5:0][5:0][35:0] ma = '0, mb = '0, mm_res;
  logic result_valid, ovf_sticky;
  logic [7:0] result_count;
  int n_chk = 0, n_fail = 0;
  bit started = 0, st_m = 0;

  typedef struct {
    bit v;
    bit sat;
    logic [7:0] cnt;
    logic [41:0][35:0] r;
  } ent_t;
  ent_t q[$];

  shared_mult_bank #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .count(count),
    .array_mult_dataa(aa), .array_mult_datab(ab),
    .mat_mult_dataa(ma), .mat_mult_datab(mb),
    .array_mult_result(am_res), .mat_mult_result(mm_res),
    .result_valid(result_valid), .result_count(result_count), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [36:0] ref_mul(input logic [35:0] a, input logic [35:0] b);
    logic signed [71:0] p, s;
    p = $signed({{36{a[35]}}, a}) * $signed({{36{b[35]}}, b});
    s = (p + 72'sd32768) >>> 16;
`ifdef SHARED_MULT_SAT_EN
    if (s > 72'sd34359738367) return {1'b1, 36'h7_FFFF_FFFF};
    if (s < -72'sd34359738368) return {1'b1, 36'h8_0000_0000};
`endif
    return {1'b0, s[35:0]};
  endfunction

  function automatic logic [35:0] lane_a(input int i);
    return i < 6 ? aa[i] : ma[(i-6)/6][(i-6)%6];
  endfunction
  function automatic logic [35:0] lane_b(input int i);
    return i < 6 ? ab[i] : mb[(i-6)/6][(i-6)%6];
  endfunction
  function automatic logic [35:0] dut_lane(input int i);
    return i < 6 ? am_res[i] : mm_res[(i-6)/6][(i-6)%6];
  endfunction

  function automatic logic [35:0] rnd36();
    logic [63:0] w;
    int s;
    if ($urandom_range(9) == 0) begin
      w = {$urandom, $urandom};
      return w[35:0];
    end
    s = int'($urandom_range(0, 1 << 23)) - (1 << 22);
    return {{4{s[31]}}, s};
  endfunction

  // reference: the output reflects the request offered LAT enabled edges ago
  always @(posedge clk) begin
    ent_t e;
    logic [36:0] t;
    if (rst) begin
      started = 1;
      st_m = 0;
      q.delete();
      e.v = 0; e.sat = 0; e.cnt = '0; e.r = '0;
      for (int k = 0; k < LAT; k++) q.push_back(e);
    end else if (en && started) begin
      e.v = req_valid; e.cnt = count; e.sat = 0;
      for (int i = 0; i < 42; i++) begin
        t = ref_mul(lane_a(i), lane_b(i));
        e.r[i] = t[35:0];
        e.sat |= t[36];
      end
      q.push_back(e);
      void'(q.pop_front());
      if (q[0].v && q[0].sat) st_m = 1;
    end
  end

  always @(negedge clk) begin
    int bad;
    if (started) begin
      chk("result_valid", result_valid, q[0].v);
      chk("ovf_sticky", ovf_sticky, st_m);
      if (q[0].v) begin
        chk("result_count", result_count, q[0].cnt);
        bad = 0;
        for (int i = 0; i < 42; i++) if (dut_lane(i) !== q[0].r[i]) begin bad = i; break; end
        chk($sformatf("lane%0d", bad), dut_lane(bad), q[0].r[bad]);
      end
    end
  end

  task automatic clear_ops();
    aa = '0; ab = '0; ma = '0; mb = '0;
  endtask

  task automatic issue(input logic [7:0] c);
    req_valid = 1; count = c; en = 1;
    @(negedge clk);
    req_valid = 0;
    clear_ops();
    repeat (LAT-1) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", result_valid, 1'b0);
    chk("rst_count", result_count, 8'h0);
    chk("rst_lane0", dut_lane(0), 36'h0);
    chk("rst_lane41", dut_lane(41), 36'h0);
    chk("rst_sticky", ovf_sticky, 1'b0);
    rst = 0;
    chk("model_2x3", ref_mul(36'h20000, 36'h30000), {1'b0, 36'h60000});
    chk("model_round_pos", ref_mul(36'h1, 36'h8000), {1'b0, 36'h1});
    chk("model_round_neg", ref_mul(36'hF_FFFF_FFFF, 36'h8000), {1'b0, 36'h0});
    // basic product: valid for exactly one cycle, LAT cycles after acceptance
    en = 1; req_valid = 1; count = 5; aa[0] = 36'h20000; ab[0] = 36'h30000;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      req_valid = 0;
      chk($sformatf("t1_valid_k%0d", k), result_valid, k == LAT);
      if (k == LAT) begin
        chk("t1_result", am_res[0], 36'h60000);
        chk("t1_count", result_count, 8'd5);
      end
    end
    clear_ops();
    // full bank: 1.0 x (r*6+c)
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        ma[r][c] = FIX_ONE;
        mb[r][c] = 36'(r*6+c) << 16;
      end
    issue(8'd2);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        chk($sformatf("t2_mat_%0d_%0d", r, c), mm_res[r][c], 36'(r*6+c) * 36'h10000);
    // rounding
    aa[0] = 36'h1; ab[0] = 36'h8000; aa[1] = 36'hF_FFFF_FFFF; ab[1] = 36'h8000;
    issue(8'd3);
    chk("t3_round_pos", am_res[0], 36'h1);
    chk("t3_round_neg", am_res[1], 36'h0);
    // stall
    req_valid = 1; count = 9; aa[2] = 36'h18000; ab[2] = 36'h20000;
    @(negedge clk);
    req_valid = 0; en = 0; clear_ops();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_stall_valid", result_valid, 1'b0);
    end
    en = 1;
    @(negedge clk);
    chk("t4_edge2_valid", result_valid, 1'b0);
    @(negedge clk);
    chk("t4_edge3_valid", result_valid, 1'b1);
    chk("t4_count", result_count, 8'd9);
    chk("t4_result", am_res[2], 36'h30000);
    en = 0;
    repeat (2) begin
      @(negedge clk);
      chk("t4_hold_valid", result_valid, 1'b1);
      chk("t4_hold_count", result_count, 8'd9);
      chk("t4_hold_result", am_res[2], 36'h30000);
    end
    en = 1;
    @(negedge clk);
    chk("t4_after_valid", result_valid, 1'b0);
    // count wrap
    req_valid = 1; count = 8'hFF;
    @(negedge clk);
    count = 8'h00;
    @(negedge clk);
    req_valid = 0;
    repeat (LAT) @(negedge clk);
    // reset mid-flight
    aa[0] = 36'h20000; ab[0] = 36'h20000;
    req_valid = 1; count = 1;
    @(negedge clk);
    count = 2;
    @(negedge clk);
    count = 3;
    @(negedge clk);
    req_valid = 0; rst = 1;
    @(negedge clk);
    chk("t5_valid", result_valid, 1'b0);
    chk("t5_count", result_count, 8'h0);
    chk("t5_lane0", am_res[0], 36'h0);
    chk("t5_lane41", mm_res[5][5], 36'h0);
    rst = 0; clear_ops();
    repeat (LAT + 1) begin
      @(negedge clk);
      chk("t5_no_valid", result_valid, 1'b0);
    end
    // overflow
    aa[0] = 36'h7_0000_0000; ab[0] = 36'h7_0000_0000;
    issue(8'd6);
`ifdef SHARED_MULT_SAT_EN
    chk("t6_result", am_res[0], 36'h7_FFFF_FFFF);
    chk("t6_sticky", ovf_sticky, 1'b1);
    repeat (3) @(negedge clk);
    chk("t6_sticky_hold", ovf_sticky, 1'b1);
`else
    chk("t6_result", am_res[0], 36'h0);
    chk("t6_sticky", ovf_sticky, 1'b0);
`endif
    rst = 1;
    @(negedge clk);
    chk("t6_sticky_rst", ovf_sticky, 1'b0);
    rst = 0;
    // random traffic
    for (int n = 0; n < 600; n++) begin
      rst = $urandom_range(99) == 0;
      en = $urandom_range(9) < 8;
      req_valid = $urandom_range(9) < 7;
      count = 8'($urandom);
      for (int i = 0; i < 6; i++) begin
        aa[i] = rnd36(); ab[i] = rnd36();
      end
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++) begin
          ma[r][c] = rnd36(); mb[r][c] = rnd36();
        end
      @(negedge clk);
    end
    rst = 0; en = 1; req_valid = 0;
    repeat (LAT + 2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
